// File: rtl/ram_readback.sv
// ram_readback: walks a contiguous RAM range with 1-cycle synchronous reads, streams each word
// over a valid/ready handshake and accumulates a mod-2**DATA_W checksum of accepted words.
`default_nettype none
`timescale 1ns/1ps

module ram_readback #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 16,
   parameter int START_ADDR = 0,
   parameter int NUM_WORDS  = 1024
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              abort,
   output logic              bus_req,
   output logic [ADDR_W-1:0] ADDR,
   output logic              rden,
   input  logic [DATA_W-1:0] q,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] checksum
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_CAPT = 3'd2,
      S_HOLD = 3'd3,
      S_DONE = 3'd4
   } state_t;

   // Counter is one bit wider than the address so a full 2**ADDR_W pass is representable.
   localparam logic [ADDR_W:0]   LAST_COUNT = (ADDR_W+1)'(NUM_WORDS - 1);
   localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(START_ADDR);

   state_t          state;
   logic [ADDR_W:0] count;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state     <= S_IDLE;
         bus_req   <= 1'b0;
         ADDR      <= '0;
         rden      <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         checksum  <= '0;
         count     <= '0;
      end else if (abort && (state != S_IDLE)) begin
         // Abort outranks start and accept; checksum keeps its partial value.
         state     <= S_IDLE;
         rden      <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         bus_req   <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start && !abort) begin
                  state    <= S_READ;
                  ADDR     <= FIRST_ADDR;
                  count    <= '0;
                  checksum <= '0;
                  done     <= 1'b0;
                  busy     <= 1'b1;
                  bus_req  <= 1'b1;
                  rden     <= 1'b1;
               end
            end
            S_READ: begin
               rden  <= 1'b0;
               state <= S_CAPT;
            end
            S_CAPT: begin
               out_data  <= q;
               out_addr  <= ADDR;
               out_valid <= 1'b1;
               state     <= S_HOLD;
            end
            S_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  checksum  <= checksum + out_data;
                  count     <= count + 1'b1;
                  if (count == LAST_COUNT) begin
                     state   <= S_DONE;
                     busy    <= 1'b0;
                     bus_req <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     ADDR  <= ADDR + 1'b1;
                     rden  <= 1'b1;
                     state <= S_READ;
                  end
               end
            end
            default: begin
               state     <= S_IDLE;
               rden      <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               bus_req   <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
